// File: rtl/frame_buffer_arbiter.sv
//----------------------------------------------------------------------------
// frame_buffer_arbiter
// Shares one frame-buffer memory port between the camera pixel writer and
// the VGA line fetcher: one access at a time, reads first, bounded write
// starvation, and a NIOS capture freeze that discards camera writes.
// Optional build macro: FB_STARVE_GUARD_EN (enables the write-starvation guard)
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module frame_buffer_arbiter #(
  parameter int AW           = 20,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_valid,
  output logic          o_rd_ready,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data,
  output logic          o_rd_data_valid,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic          i_mem_ack,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_freeze,
  output logic          o_frozen,
  output logic [15:0]   o_drop_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  state_t          state_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [DW-1:0]   rd_data_q;
  logic            rd_data_valid_q;
  logic            frozen_q;
  logic [15:0]     drop_cnt_q;
  logic [15:0]     drop_cnt_d;

  logic            idle;
  logic            wr_elig;
  logic            starve_hit;
  logic            wr_win;
  logic            wr_grant;
  logic            rd_grant;
  logic            drop;

  // Arbitration is only meaningful in S_IDLE; a frozen write never competes.
  // Gating with i_rst_n keeps both readies low while reset is held.
  assign idle     = (state_q == S_IDLE);
  assign wr_elig  = i_wr_valid & ~frozen_q;
  assign wr_win   = wr_elig & (~i_rd_valid | starve_hit);
  assign wr_grant = i_rst_n & idle & wr_win;
  assign rd_grant = i_rst_n & idle & i_rd_valid & ~wr_win;
  assign drop     = frozen_q & i_wr_valid;

  // While frozen every camera write is swallowed, whatever the FSM is doing.
  assign o_wr_ready = wr_grant | frozen_q;
  assign o_rd_ready = rd_grant;

`ifdef FB_STARVE_GUARD_EN
  localparam logic [7:0] c_limit = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt_q;
  logic [7:0] starve_cnt_d;

  // Count reads granted over a waiting write; reset once the write gets in
  // or nothing is waiting.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (wr_grant || (idle && !wr_elig)) begin
      starve_cnt_d = 8'd0;
    end else if (rd_grant && wr_elig && (starve_cnt_q != 8'hFF)) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt_q <= 8'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starve_hit = (starve_cnt_q >= c_limit);
`else
  // Strict read priority: the limit is never 0 in a legal build, so a
  // competing read always wins.
  assign starve_hit = (STARVE_LIMIT == 0);
`endif

  // Drop counter restarts when a freeze begins and saturates at all-ones.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (i_freeze && !frozen_q) begin
      drop_cnt_d = 16'd0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Freeze flag and drop counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frozen_q   <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      frozen_q   <= i_freeze;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Access FSM: latch the granted request, hold it on the memory port until ack.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= S_IDLE;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      rd_data_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wr_grant) begin
            state_q     <= S_WR;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= i_wr_addr;
            mem_wdata_q <= i_wr_data;
          end else if (rd_grant) begin
            state_q    <= S_RD;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= i_rd_addr;
          end
        end
        S_WR: begin
          if (i_mem_ack) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        S_RD: begin
          if (i_mem_ack) begin
            state_q         <= S_IDLE;
            mem_req_q       <= 1'b0;
            rd_data_q       <= i_mem_rdata;
            rd_data_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req       = mem_req_q;
  assign o_mem_we        = mem_we_q;
  assign o_mem_addr      = mem_addr_q;
  assign o_mem_wdata     = mem_wdata_q;
  assign o_rd_data       = rd_data_q;
  assign o_rd_data_valid = rd_data_valid_q;
  assign o_frozen        = frozen_q;
  assign o_drop_count    = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_buffer_arbiter.sv
//----------------------------------------------------------------------------
// tb_frame_buffer_arbiter
// Directed self-checking bench for frame_buffer_arbiter.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_frame_buffer_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          freeze;
  logic          frozen;
  logic [15:0]   drop_count;

  int checks = 0;
  int errors = 0;

  frame_buffer_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(8)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_wr_valid     (wr_valid),
    .o_wr_ready     (wr_ready),
    .i_wr_addr      (wr_addr),
    .i_wr_data      (wr_data),
    .i_rd_valid     (rd_valid),
    .o_rd_ready     (rd_ready),
    .i_rd_addr      (rd_addr),
    .o_rd_data      (rd_data),
    .o_rd_data_valid(rd_data_valid),
    .o_mem_req      (mem_req),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .i_mem_ack      (mem_ack),
    .i_mem_rdata    (mem_rdata),
    .i_freeze       (freeze),
    .o_frozen       (frozen),
    .o_drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Return 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},   32'(mem_req), 32'd0);
    check({tag, "_mem_we"},    32'(mem_we), 32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_rd_data"},   32'(rd_data), 32'd0);
    check({tag, "_rd_dvalid"}, 32'(rd_data_valid), 32'd0);
    check({tag, "_frozen"},    32'(frozen), 32'd0);
    check({tag, "_drop"},      32'(drop_count), 32'd0);
    check({tag, "_wr_ready"},  32'(wr_ready), 32'd0);
    check({tag, "_rd_ready"},  32'(rd_ready), 32'd0);
  endtask

  initial begin
    int k;
    int wr_cnt;
    int rd_cnt;
    int pulse_cnt;
    logic exp_we;

    // ---------------- reset, with requests present ----------------
    rst_n     = 1'b0;
    wr_valid  = 1'b1;
    rd_valid  = 1'b1;
    wr_addr   = 20'h11111;
    wr_data   = 16'h1110;
    rd_addr   = 20'h22222;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    freeze    = 1'b0;
    #2;
    check("rst_wr_ready_early", 32'(wr_ready), 32'd0);
    check("rst_rd_ready_early", 32'(rd_ready), 32'd0);
    tick();
    tick();
    check_all_zero("reset");
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    rst_n    = 1'b1;
    tick();

    // ---------------- single write, immediate ack ----------------
    wr_valid = 1'b1;
    wr_addr  = 20'h00010;
    wr_data  = 16'hABC0;
    #1;
    check("wr1_wr_ready", 32'(wr_ready), 32'd1);
    check("wr1_rd_ready", 32'(rd_ready), 32'd0);
    tick();
    wr_valid = 1'b0;
    wr_addr  = 20'hFFFFF;
    wr_data  = 16'h0000;
    mem_ack  = 1'b1;
    #1;
    check("wr1_req",      32'(mem_req), 32'd1);
    check("wr1_we",       32'(mem_we), 32'd1);
    check("wr1_addr",     32'(mem_addr), 32'h00010);
    check("wr1_wdata",    32'(mem_wdata), 32'hABC0);
    check("wr1_ready_lo", 32'(wr_ready), 32'd0);
    tick();
    mem_ack = 1'b0;
    check("wr1_req_drop", 32'(mem_req), 32'd0);

    // ---------------- read, ack after 3 wait cycles ----------------
    rd_valid = 1'b1;
    rd_addr  = 20'h12345;
    #1;
    check("rd1_rd_ready", 32'(rd_ready), 32'd1);
    tick();
    rd_valid = 1'b0;
    rd_addr  = 20'h00000;
    check("rd1_req_c1",  32'(mem_req), 32'd1);
    check("rd1_we",      32'(mem_we), 32'd0);
    check("rd1_addr",    32'(mem_addr), 32'h12345);
    #1;
    check("rd1_busy_ready", 32'(rd_ready), 32'd0);
    tick();
    check("rd1_req_c2", 32'(mem_req), 32'd1);
    tick();
    check("rd1_req_c3", 32'(mem_req), 32'd1);
    tick();
    check("rd1_req_c4",    32'(mem_req), 32'd1);
    check("rd1_dv_early",  32'(rd_data_valid), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 16'h5A50;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    check("rd1_req_off", 32'(mem_req), 32'd0);
    check("rd1_dv",      32'(rd_data_valid), 32'd1);
    check("rd1_data",    32'(rd_data), 32'h5A50);
    tick();
    check("rd1_dv_pulse", 32'(rd_data_valid), 32'd0);

    // ---------------- both valid continuously ----------------
    wr_valid = 1'b1;
    wr_addr  = 20'hAAAAA;
    wr_data  = 16'hAAA0;
    rd_valid = 1'b1;
    rd_addr  = 20'h55555;
    mem_ack  = 1'b1;
    k = 0;
    for (int c = 0; c < 36; c++) begin
      tick();
      if (mem_req) begin
`ifdef FB_STARVE_GUARD_EN
        exp_we = ((k % 9) == 8);
`else
        exp_we = 1'b0;
`endif
        check("pattern_we",   32'(mem_we), 32'(exp_we));
        check("pattern_addr", 32'(mem_addr), exp_we ? 32'hAAAAA : 32'h55555);
        k++;
      end
    end
    check("pattern_count", 32'(k), 32'd18);
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    mem_ack  = 1'b0;
    tick();

    // ---------------- freeze with a write in flight ----------------
    wr_valid = 1'b1;
    wr_addr  = 20'h00020;
    wr_data  = 16'h1230;
    tick();
    wr_valid = 1'b0;
    freeze   = 1'b1;
    check("frz_inflight_req", 32'(mem_req), 32'd1);
    tick();
    check("frz_frozen",       32'(frozen), 32'd1);
    check("frz_drop_clear",   32'(drop_count), 32'd0);
    check("frz_inflight_we",  32'(mem_we), 32'd1);
    check("frz_inflight_ok",  32'(mem_addr), 32'h00020);
    check("frz_wr_ready_busy", 32'(wr_ready), 32'd1);
    mem_ack = 1'b1;
    tick();
    check("frz_inflight_done", 32'(mem_req), 32'd0);

    // 20 writes discarded while reads keep flowing
    wr_valid = 1'b1;
    wr_addr  = 20'h00030;
    rd_valid = 1'b1;
    rd_addr  = 20'h00040;
    wr_cnt    = 0;
    rd_cnt    = 0;
    pulse_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mem_req && mem_we)  wr_cnt++;
      if (mem_req && !mem_we) rd_cnt++;
      if (rd_data_valid)      pulse_cnt++;
    end
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    mem_ack  = 1'b0;
    check("frz_no_writes",  32'(wr_cnt), 32'd0);
    check("frz_reads",      32'(rd_cnt), 32'd10);
    check("frz_rd_returns", 32'(pulse_cnt), 32'd10);
    check("frz_drop20",     32'(drop_count), 32'd20);

    // re-freeze restarts the count
    freeze = 1'b0;
    tick();
    check("unfrz_frozen", 32'(frozen), 32'd0);
    freeze = 1'b1;
    tick();
    check("refrz_frozen", 32'(frozen), 32'd1);
    check("refrz_drop0",  32'(drop_count), 32'd0);

    // ---------------- saturation: 70000 frozen writes ----------------
    wr_valid = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    check("sat_drop3", 32'(drop_count), 32'd3);
    for (int c = 0; c < 65531; c++) tick();
    check("sat_drop_fffe", 32'(drop_count), 32'hFFFE);
    for (int c = 0; c < 4466; c++) tick();
    check("sat_drop_ffff", 32'(drop_count), 32'hFFFF);
    check("sat_no_access", 32'(mem_req), 32'd0);
    wr_valid = 1'b0;
    freeze   = 1'b0;
    tick();
    tick();

    // ---------------- async reset during a pending read ----------------
    rd_valid = 1'b1;
    rd_addr  = 20'h0BEEF;
    #1;
    check("ar_rd_ready", 32'(rd_ready), 32'd1);
    tick();
    rd_valid = 1'b0;
    check("ar_req", 32'(mem_req), 32'd1);
    tick();
    check("ar_req_hold", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_all_zero("post_rst");
    rd_valid = 1'b1;
    rd_addr  = 20'h00001;
    #1;
    check("post_rst_idle", 32'(rd_ready), 32'd1);
    rd_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frame_buffer_arbiter.md
# frame_buffer_arbiter

Shares the single frame-buffer memory port (20-bit word address, 16-bit data) between the camera pixel writer and the VGA line fetcher. It serialises one access at a time, gives reads priority, and bounds write starvation. It also implements the NIOS capture freeze: while frozen, camera writes are acknowledged but discarded, so the stored frame stays intact while the display and NIOS keep reading it.

## Interface
- AW, 20, memory word-address width
- DW, 16, memory data width (RGB444 in [15:4], [3:0] zero)
- STARVE_LIMIT, 8, consecutive read grants tolerated while a write waits (range 1..255)

- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_wr_valid  in  1  camera write request
- o_wr_ready  out  1  write accepted this cycle when high with i_wr_valid
- i_wr_addr  in  AW  write address
- i_wr_data  in  DW  write data
- i_rd_valid  in  1  VGA read request
- o_rd_ready  out  1  read accepted this cycle when high with i_rd_valid
- i_rd_addr  in  AW  read address
- o_rd_data  out  DW  returned read data
- o_rd_data_valid  out  1  one-cycle pulse; o_rd_data valid
- o_mem_req  out  1  memory access request, held until i_mem_ack
- o_mem_we  out  1  1 = write, 0 = read; stable while o_mem_req
- o_mem_addr  out  AW  memory address; stable while o_mem_req
- o_mem_wdata  out  DW  memory write data; stable while o_mem_req
- i_mem_ack  in  1  access complete; read data valid this cycle
- i_mem_rdata  in  DW  memory read data
- i_freeze  in  1  NIOS capture freeze request (level)
- o_frozen  out  1  freeze in effect
- o_drop_count  out  16  camera writes discarded in the current freeze, saturating

## Operation
- FSM states:
  - S_IDLE: arbitrate and accept one request.
  - S_WR: o_mem_req=1, o_mem_we=1 until i_mem_ack, then go to S_IDLE.
  - S_RD: o_mem_req=1, o_mem_we=0 until i_mem_ack; register i_mem_rdata into o_rd_data, then go to S_IDLE.
- Arbitration (S_IDLE only, combinational on current valids):
  - Read valid and no eligible write: o_rd_ready=1.
  - Eligible write and no read: o_wr_ready=1.
  - Both valid: read wins, unless the starvation rule applies (Configuration).
  - At most one of o_wr_ready and o_rd_ready reaches memory per cycle.
- Accepted request: address and data are latched into o_mem_addr and o_mem_wdata. Requesters may change inputs after the handshake.
- Freeze:
  - o_frozen <= i_freeze every cycle (one-cycle registration).
  - While o_frozen=1, o_wr_ready=1 in every state. Any i_wr_valid is consumed without a memory access, and o_drop_count increments, saturating at 0xFFFF.
  - A write already in S_WR when freeze asserts completes normally.
  - While frozen, writes are never eligible for arbitration. Reads proceed unchanged.
  - o_drop_count clears to 0 on the cycle o_frozen rises.
- Simultaneous events:
  - A frozen drop and a read grant in the same S_IDLE cycle are both performed.
  - A new freeze coinciding with a write acceptance: the acceptance uses the old o_frozen value.
- Reset:
  - Any state returns to S_IDLE and o_mem_req drops immediately. The memory controller tolerates an abandoned access.
  - Reset values are 0 for all outputs (o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_rd_data, o_rd_data_valid, o_frozen, o_drop_count, o_wr_ready, o_rd_ready), and 0 for the starvation counter.
  - o_wr_ready and o_rd_ready are combinational. They are low during reset because the FSM is in S_IDLE with o_frozen=0 and the valids are ignored while reset is asserted.

## Timing
- Handshake cycle N → o_mem_req high at N+1 with address, data and we valid.
- i_mem_ack at cycle M (≥ N+1) → FSM back in S_IDLE at M+1. The next handshake can occur at M+1.
- Read return: o_rd_data_valid pulses at M+1 with o_rd_data = i_mem_rdata sampled at M.
- Best-case throughput: one access per 2 cycles (ack the same cycle as o_mem_req).
- Freeze takes effect for handshakes starting one cycle after i_freeze changes.

## Configuration
- FB_STARVE_GUARD_EN defined:
  - An 8-bit counter increments on each read grant made while i_wr_valid=1 and o_frozen=0.
  - It clears on a write grant, and on any S_IDLE cycle where no write is pending.
  - When counter ≥ STARVE_LIMIT and both are valid, the write wins.
- Not defined: strict read priority with no counter, so writes can starve indefinitely.

## Test plan
- Single write 0x00010 ← 0xABC0, ack on the first req cycle → o_mem_req high exactly 1 cycle with we=1 and the correct address/data; o_wr_ready pulses once.
- Read 0x12345 with ack delayed 3 cycles, i_mem_rdata=0x5A50 → o_mem_req high 4 cycles; o_rd_data_valid pulses 1 cycle after ack with 0x5A50.
- Both valid continuously with guard enabled and STARVE_LIMIT=8 → grant pattern of 8 reads then 1 write, repeating. With the macro undefined → reads only.
- Assert i_freeze, then stream 20 writes with reads interleaved → no o_mem_we=1 accesses after the in-flight write; o_drop_count=20; reads still serviced. Re-freeze → count restarts at 0.
- 70000 writes while frozen → o_drop_count saturates at 0xFFFF.
- Assert i_rst_n low while in S_RD waiting for ack → o_mem_req drops asynchronously; after release, FSM is in S_IDLE and all outputs are 0.
